ibex_register_file_init_ctrl: RTL and testbench

- Writer-side controller that sits between the writeback stage and the FPGA register file's single write port.
- The FPGA register file has no reset, so after reset (or on request) this block sequentially writes WordZeroVal to every architectural register.
- It can optionally read every register back through read port A and compare.
- After that it becomes a transparent pass-through for core writes.

---
 rtl/ibex_register_file_init_ctrl_if.sv | 25 ++
 rtl/ibex_register_file_init_ctrl.sv | 76 +++++++
 tb/tb_ibex_register_file_init_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ibex_register_file_init_ctrl_if.sv
// ibex_register_file_init_ctrl_if: core writeback and register-file port bundle
// core_*  : write request from the writeback stage
// rf_w*   : register file write port
// rf_r*   : register file read port A (asynchronous read)
// master  : core/register-file side; slave : init controller side
interface ibex_register_file_init_ctrl_if #(
  parameter int DataWidth = 32
);
  logic [4:0]           core_waddr;
  logic [DataWidth-1:0] core_wdata;
  logic                 core_we;
  logic [4:0]           rf_waddr;
  logic [DataWidth-1:0] rf_wdata;
  logic                 rf_we;
  logic [4:0]           rf_raddr;
  logic [DataWidth-1:0] rf_rdata;
  modport master (
    output core_waddr, core_wdata, core_we, rf_rdata,
    input  rf_waddr, rf_wdata, rf_we, rf_raddr
  );
  modport slave (
    input  core_waddr, core_wdata, core_we, rf_rdata,
    output rf_waddr, rf_wdata, rf_we, rf_raddr
  );
endinterface

// File: rtl/ibex_register_file_init_ctrl.sv
// ibex_register_file_init_ctrl: clears a reset-less register file, optionally verifies it, then passes core writes through
// clk_i/rst_i : clock, synchronous active-high reset
// start_i     : re-initialisation request, taken only in DONE or ERROR
// bus         : core write request in, register file write/read ports out
// busy_o      : sweep in progress (core writes refused)
// done_o      : file initialised, pass-through active
// err_o       : read-back mismatch, held until start_i
// drop_o      : a core write was discarded this cycle
module ibex_register_file_init_ctrl #(
  parameter bit                   RV32E       = 1'b0,
  parameter int                   DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter bit                   VerifyEn    = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  ibex_register_file_init_ctrl_if.slave bus,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  output logic drop_o
);
  typedef enum logic [1:0] {WRITE, VERIFY, DONE, ERROR} state_e;
  localparam logic [4:0] Last = RV32E ? 5'd15 : 5'd31;
  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WRITE;
      cnt_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WRITE: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == Last) begin
          state_d = VerifyEn ? VERIFY : DONE;
          cnt_d   = 5'd1;
        end
      end
      VERIFY: begin
        if (bus.rf_rdata != WordZeroVal) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == Last) begin
            state_d = DONE;
            cnt_d   = 5'd1;
          end
        end
      end
      default: begin
        if (start_i) begin
          state_d = WRITE;
          cnt_d   = 5'd1;
        end
      end
    endcase
  end
  // outputs are gated by rst_i so reset cycles look idle even before the first edge
  assign bus.rf_we    = ~rst_i & ((state_q == WRITE) | ((state_q == DONE) & bus.core_we));
  assign bus.rf_waddr = (state_q == DONE) ? bus.core_waddr : cnt_q;
  assign bus.rf_wdata = (state_q == DONE) ? bus.core_wdata : WordZeroVal;
  assign bus.rf_raddr = (state_q == VERIFY) ? cnt_q : 5'd0;
  assign busy_o = rst_i | (state_q != DONE);
  assign done_o = ~rst_i & (state_q == DONE);
  assign err_o  = ~rst_i & (state_q == ERROR);
  assign drop_o = ~rst_i & bus.core_we & (state_q != DONE);
endmodule

// File: tb/tb_ibex_register_file_init_ctrl.sv
// tb_ibex_register_file_init_ctrl: three configurations against a timeline reference model
module tb_ibex_register_file_init_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, core_we;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;
  logic [2:0]  corrupt;
  logic [2:0]  we, busy, done, err, drop;
  logic [4:0]  waddr [3];
  logic [4:0]  raddr [3];
  logic [31:0] wdata [3];
  int          n_checks = 0;
  int          n_fail = 0;
  int          t [3];
  bit          merr [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    logic [31:0] rf [32];
    ibex_register_file_init_ctrl_if #(.DataWidth(32)) ifc ();
    ibex_register_file_init_ctrl #(
      .RV32E(g == 1),
      .DataWidth(32),
      .WordZeroVal(g == 1 ? 32'hA5A5_0000 : g == 2 ? 32'h1234_5678 : 32'h0),
      .VerifyEn(g != 2)
    ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .bus(ifc.slave),
      .busy_o(busy[g]), .done_o(done[g]), .err_o(err[g]), .drop_o(drop[g])
    );
    assign ifc.core_waddr = core_waddr;
    assign ifc.core_wdata = core_wdata;
    assign ifc.core_we    = core_we;
    assign ifc.rf_rdata   = (corrupt[g] && ifc.rf_raddr == 5'd7) ? 32'h1 : rf[ifc.rf_raddr];
    always @(posedge clk) if (ifc.rf_we) rf[ifc.rf_waddr] <= ifc.rf_wdata;
    assign we[g]    = ifc.rf_we;
    assign waddr[g] = ifc.rf_waddr;
    assign wdata[g] = ifc.rf_wdata;
    assign raddr[g] = ifc.rf_raddr;
  end
  function automatic int last_of(int k);
    return k == 1 ? 15 : 31;
  endfunction
  function automatic logic [31:0] wzv(int k);
    return k == 1 ? 32'hA5A5_0000 : k == 2 ? 32'h1234_5678 : 32'h0;
  endfunction
  task automatic check(string tag, int k, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: got %0h expected %0h", tag, k, got, exp);
    end
  endtask
  // One clock: check every instance at the falling edge, then advance the model.
  // Model: t = cycles since the last restart; writes occupy t<L, reads L<=t<2L (if enabled).
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      int          l = last_of(k);
      bit          v = (k != 2);
      logic [31:0] w = wzv(k);
      logic        e_we = 1'b0, e_busy = 1'b1, e_done = 1'b0, e_err = 1'b0, e_drop = 1'b0;
      logic [4:0]  e_wa = '0, e_ra = '0;
      logic [31:0] e_wd = '0;
      bit          in_verify = 1'b0, in_done = 1'b0, chk_ra = 1'b1;
      if (rst) begin
        chk_ra = 1'b0;
      end else if (merr[k]) begin
        e_err = 1'b1; e_drop = core_we; chk_ra = 1'b0;
      end else if (t[k] < l) begin
        e_we = 1'b1; e_wa = 5'(t[k] + 1); e_wd = w; e_drop = core_we;
      end else if (v && t[k] < 2 * l) begin
        in_verify = 1'b1; e_ra = 5'(t[k] - l + 1); e_drop = core_we;
      end else begin
        in_done = 1'b1; e_busy = 1'b0; e_done = 1'b1;
        e_we = core_we; e_wa = core_waddr; e_wd = core_wdata;
      end
      check("rf_we", k, 32'(we[k]), 32'(e_we));
      check("busy", k, 32'(busy[k]), 32'(e_busy));
      check("done", k, 32'(done[k]), 32'(e_done));
      check("err", k, 32'(err[k]), 32'(e_err));
      check("drop", k, 32'(drop[k]), 32'(e_drop));
      if (chk_ra) check("rf_raddr", k, 32'(raddr[k]), 32'(e_ra));
      if (e_we) begin
        check("rf_waddr", k, 32'(waddr[k]), 32'(e_wa));
        check("rf_wdata", k, wdata[k], e_wd);
      end
      if (rst) begin
        t[k] = 0; merr[k] = 1'b0;
      end else if ((merr[k] || in_done) && start) begin
        t[k] = 0; merr[k] = 1'b0;
      end else if (in_verify && ((corrupt[k] && e_ra == 5'd7) ? 32'h1 : w) != w) begin
        merr[k] = 1'b1;
      end else if (!merr[k] && !in_done) begin
        t[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rand_core();
    core_we    = 1'($urandom);
    core_waddr = 5'($urandom);
    core_wdata = $urandom;
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      rand_core();
      step();
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; corrupt = '0;
    core_we = 1'b0; core_waddr = '0; core_wdata = '0;
    for (int k = 0; k < 3; k++) begin t[k] = 0; merr[k] = 1'b0; end
    run(3);
    rst = 1'b0;
    run(3);
    core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hDEAD_BEEF;
    step();
    run(6);
    start = 1'b1;
    rand_core();
    step();
    start = 1'b0;
    run(60);
    core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hCAFE_0005;
    step();
    core_we = 1'b1; core_waddr = 5'd0; core_wdata = 32'h0BAD_0000;
    step();
    start = 1'b1;
    core_we = 1'b1; core_waddr = 5'd9; core_wdata = 32'h1111_2222;
    corrupt = 3'b011;
    step();
    start = 1'b0;
    run(70);
    corrupt = '0;
    start = 1'b1;
    rand_core();
    step();
    start = 1'b0;
    run(40);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(70);
    for (int i = 0; i < 250; i++) begin
      start   = ($urandom_range(0, 15) == 0);
      corrupt = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      rand_core();
      step();
    end
    start = 1'b0; corrupt = '0;
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(70);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
